// File: rtl/fcn_pkg.sv
// Shared types and constants for the fully connected requantizing serializer.
// Build option FCN_LEAKY_RELU_EN selects leaky instead of clamping activation.
package fcn_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_ACC_WIDTH   = 32;
  localparam int DEF_SHIFT_WIDTH = 5;

  localparam int LEAKY_SHIFT = 3;

  localparam logic signed [DEF_DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DEF_DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/fcn_requant_unit.sv
// Combinational requantizer: rounding arithmetic right shift, saturation, activation.
// FCN_LEAKY_RELU_EN turns the negative-clamp activation into a floor shift by LEAKY_SHIFT.
module fcn_requant_unit
  import fcn_pkg::*;
#(
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0]   x,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  input  logic                          relu_en,
  output logic signed [DATA_WIDTH-1:0]  y
);

  // Limits widened to ACC_WIDTH+1 so the post-shift value compares without truncation.
  localparam logic signed [ACC_WIDTH:0] MAX_EXT =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MIN_EXT =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0]    ext_s;
  logic signed [ACC_WIDTH:0]    rnd_s;
  logic signed [ACC_WIDTH:0]    sum_s;
  logic signed [ACC_WIDTH:0]    shifted_s;
  logic signed [DATA_WIDTH-1:0] sat_s;

  // Round, shift, saturate and activate one element.
  always_comb begin
    ext_s     = {x[ACC_WIDTH-1], x};
    rnd_s     = {(ACC_WIDTH+1){1'b0}};
    sum_s     = ext_s;
    shifted_s = ext_s;
    sat_s     = {DATA_WIDTH{1'b0}};
    y         = {DATA_WIDTH{1'b0}};

    if (shift != {SHIFT_WIDTH{1'b0}}) begin
      rnd_s     = (ACC_WIDTH+1)'(1) << (shift - SHIFT_WIDTH'(1));
      sum_s     = ext_s + rnd_s;
      shifted_s = sum_s >>> shift;
    end else begin
      shifted_s = ext_s;
    end

    if (shifted_s > MAX_EXT) begin
      sat_s = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (shifted_s < MIN_EXT) begin
      sat_s = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      sat_s = shifted_s[DATA_WIDTH-1:0];
    end

    if (relu_en && sat_s[DATA_WIDTH-1]) begin
`ifdef FCN_LEAKY_RELU_EN
      y = sat_s >>> LEAKY_SHIFT;
`else
      y = {DATA_WIDTH{1'b0}};
`endif
    end else begin
      y = sat_s;
    end
  end

endmodule

// File: rtl/fcn_requant_serializer.sv
// Captures an M-element accumulator vector and streams requantized elements one per cycle.
// Activation flavour follows FCN_LEAKY_RELU_EN (see fcn_requant_unit).
module fcn_requant_serializer
  import fcn_pkg::*;
#(
  parameter int M           = 4,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [M-1:0][ACC_WIDTH-1:0]   in_vec,
  input  logic [SHIFT_WIDTH-1:0]        in_shift,
  input  logic                          in_relu_en,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic signed [DATA_WIDTH-1:0]  out_data,
  output logic [$clog2(M)-1:0]          out_idx,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int IDX_W = $clog2(M);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(M-1);

  state_t                      state_r, state_nx;
  logic [IDX_W-1:0]            idx_r, idx_nx;
  logic [M-1:0][ACC_WIDTH-1:0] vec_r;
  logic [SHIFT_WIDTH-1:0]      shift_r;
  logic                        relu_r;
  logic                        load_s;
  logic                        last_s;
  logic                        out_hs_s;
  logic                        ready_s;

  // Next-state, index and load control; a last-element handshake may reload back-to-back.
  always_comb begin
    state_nx = state_r;
    idx_nx   = idx_r;
    load_s   = 1'b0;
    last_s   = (idx_r == LAST_IDX);
    out_hs_s = (state_r == BUSY) && out_ready;
    ready_s  = (state_r == IDLE) || (out_hs_s && last_s);

    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nx = BUSY;
          idx_nx   = {IDX_W{1'b0}};
          load_s   = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      BUSY: begin
        if (out_hs_s) begin
          if (last_s) begin
            idx_nx = {IDX_W{1'b0}};
            if (in_valid) begin
              load_s = 1'b1;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            idx_nx = idx_r + IDX_W'(1);
          end
        end else begin
          state_nx = BUSY;
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State, index and captured vector registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= {IDX_W{1'b0}};
      vec_r   <= {(M*ACC_WIDTH){1'b0}};
      shift_r <= {SHIFT_WIDTH{1'b0}};
      relu_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      idx_r   <= idx_nx;
      if (load_s) begin
        vec_r   <= in_vec;
        shift_r <= in_shift;
        relu_r  <= in_relu_en;
      end
    end
  end

  fcn_requant_unit #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH)
  ) u_requant (
    .x      ($signed(vec_r[idx_r])),
    .shift  (shift_r),
    .relu_en(relu_r),
    .y      (out_data)
  );

  assign in_ready  = ready_s;
  assign out_valid = (state_r == BUSY);
  assign out_idx   = idx_r;
  assign out_last  = last_s;

endmodule

// File: tb/tb_fcn_requant_serializer.sv
// Directed self-checking bench for fcn_requant_serializer (M=4, 16-bit out, 32-bit acc).
// Expected activation results follow FCN_LEAKY_RELU_EN when defined.
module tb_fcn_requant_serializer;

  logic              clk;
  logic              rst;
  logic [3:0][31:0]  in_vec;
  logic [4:0]        in_shift;
  logic              in_relu_en;
  logic              in_valid;
  logic              in_ready;
  logic signed [15:0] out_data;
  logic [1:0]        out_idx;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  int n_tests;
  int n_fail;

  fcn_requant_serializer #(
    .M(4), .DATA_WIDTH(16), .ACC_WIDTH(32), .SHIFT_WIDTH(5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vec    (in_vec),
    .in_shift  (in_shift),
    .in_relu_en(in_relu_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0][31:0] pack4(input logic [31:0] a0, input logic [31:0] a1,
                                             input logic [31:0] a2, input logic [31:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  // Present a vector in IDLE for one accept cycle.
  task automatic send(input logic [3:0][31:0] v, input logic [4:0] sh, input logic relu);
    in_vec     = v;
    in_shift   = sh;
    in_relu_en = relu;
    in_valid   = 1'b1;
    chk("send_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Check four consecutive output elements with out_ready held high.
  task automatic burst(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                       input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] e [4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("%s_idx%0d", tag, i), {30'd0, out_idx}, 32'(i));
      chk($sformatf("%s_data%0d", tag, i), {16'd0, out_data}, {16'd0, e[i]});
      chk($sformatf("%s_last%0d", tag, i), {31'd0, out_last}, (i == 3) ? 32'd1 : 32'd0);
      step();
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    clk        = 1'b0;
    rst        = 1'b1;
    in_vec     = '0;
    in_shift   = 5'd0;
    in_relu_en = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;

    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_idx", {30'd0, out_idx}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    #1 rst = 1'b0;
    step();
    out_ready = 1'b1;

    // 1: pass-through with positive saturation
    send(pack4(32'sd1000, -32'sd1000, 32'sd70000, 32'sd5), 5'd0, 1'b0);
    burst("t1", 16'sd1000, -16'sd1000, 16'sd32767, 16'sd5);
    chk("t1_idle", {31'd0, out_valid}, 32'd0);

    // 2: rounding shift and extremes
    send(pack4(32'sd24, 32'sd23, -32'sd24, -32'sd25), 5'd4, 1'b0);
    burst("t2a", 16'sd2, 16'sd1, -16'sd1, -16'sd2);
    send(pack4(-32'sd2147483648, 32'sd2147483647, -32'sd32769, 32'sd32767), 5'd0, 1'b0);
    burst("t2b", -16'sd32768, 16'sd32767, -16'sd32768, 16'sd32767);
    send(pack4(32'sd2147483647, -32'sd2147483648, 32'sd0, -32'sd1), 5'd31, 1'b0);
    burst("t2c", 16'sd1, -16'sd1, 16'sd0, 16'sd0);

    // 3: activation
    send(pack4(-32'sd1000, -32'sd1, 32'sd0, 32'sd300), 5'd0, 1'b1);
`ifdef FCN_LEAKY_RELU_EN
    burst("t3", -16'sd125, -16'sd1, 16'sd0, 16'sd300);
`else
    burst("t3", 16'sd0, 16'sd0, 16'sd0, 16'sd300);
`endif

    // 4: backpressure at idx 1
    send(pack4(32'sd40, 32'sd30, 32'sd20, 32'sd10), 5'd0, 1'b0);
    chk("t4_idx0", {30'd0, out_idx}, 32'd0);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t4_hold_valid%0d", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("t4_hold_idx%0d", i), {30'd0, out_idx}, 32'd1);
      chk($sformatf("t4_hold_data%0d", i), {16'd0, out_data}, 32'd30);
      chk($sformatf("t4_hold_ready%0d", i), {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("t4_resume_idx", {30'd0, out_idx}, 32'd2);
    chk("t4_resume_data", {16'd0, out_data}, 32'd20);
    step();
    chk("t4_last", {31'd0, out_last}, 32'd1);
    step();
    chk("t4_idle", {31'd0, out_valid}, 32'd0);

    // 5: back-to-back vectors, no bubble
    in_vec   = pack4(32'sd1, 32'sd2, 32'sd3, 32'sd4);
    in_shift = 5'd0;
    in_relu_en = 1'b0;
    in_valid = 1'b1;
    step();
    in_vec = pack4(-32'sd5, -32'sd6, -32'sd7, -32'sd8);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5a_idx%0d", i), {30'd0, out_idx}, 32'(i));
      chk($sformatf("t5a_data%0d", i), {16'd0, out_data}, 32'(i + 1));
      chk($sformatf("t5a_ready%0d", i), {31'd0, in_ready}, (i == 3) ? 32'd1 : 32'd0);
      step();
    end
    in_valid = 1'b0;
    burst("t5b", -16'sd5, -16'sd6, -16'sd7, -16'sd8);
    chk("t5_idle", {31'd0, out_valid}, 32'd0);

    // 6: async reset mid-burst
    send(pack4(32'sd7, 32'sd8, 32'sd9, 32'sd10), 5'd0, 1'b0);
    step();
    step();
    chk("t6_idx2", {30'd0, out_idx}, 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_idx", {30'd0, out_idx}, 32'd0);
    #2 rst = 1'b0;
    step();
    chk("t6_post_ready", {31'd0, in_ready}, 32'd1);
    chk("t6_post_idx", {30'd0, out_idx}, 32'd0);
    chk("t6_post_valid", {31'd0, out_valid}, 32'd0);
    send(pack4(32'sd100, -32'sd100, 32'sd50, -32'sd50), 5'd1, 1'b0);
    burst("t6", 16'sd50, -16'sd50, 16'sd25, -16'sd25);
    chk("t6_idle", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fcn_requant_serializer.md
Name: fcn_requant_serializer

Overview:
- Downstream neighbour of the fully connected matrix-multiply stage.
- Captures one M-element signed accumulator vector through a valid/ready handshake.
- Requantizes each element to DATA_WIDTH: rounding right shift, saturation, optional ReLU.
- Streams the results out one element per cycle, with index and last flags, to the next layer's input buffer.

Parameters:
M, 4, elements per accumulator vector (M >= 2)
DATA_WIDTH, 16, signed output element width
ACC_WIDTH, 32, signed accumulator input element width
SHIFT_WIDTH, 5, width of the requant shift amount (shift range 0..2^SHIFT_WIDTH-1, must be < ACC_WIDTH)

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock; reset is asynchronous and active-high
in_vec  input  ACC_WIDTH x [M]  signed accumulator vector (fully connected stage output)
in_shift  input  SHIFT_WIDTH  right-shift amount; sampled with the vector
in_relu_en  input  1  activation enable; sampled with the vector
in_valid  input  1  vector valid
in_ready  output  1  vector accepted when in_valid && in_ready
out_data  output  DATA_WIDTH  signed requantized element
out_idx  output  $clog2(M)  element index 0..M-1
out_last  output  1  high when out_idx == M-1
out_valid  output  1  element valid
out_ready  input  1  downstream accept

Behaviour:
- States: IDLE, BUSY. Reset state: IDLE, idx=0.
- Reset values: out_valid=0, out_last=0, out_idx=0, out_data=0. in_ready is 1 out of reset.
- in_ready = (state==IDLE) || (state==BUSY && out_valid && out_ready && out_last).
- Accept: on in_valid && in_ready, register in_vec, in_shift and in_relu_en. Set idx=0 and state=BUSY.
- First element is valid the cycle after accept (latency 1). One element per cycle while out_ready=1.
- out_valid = (state==BUSY).
- out_data, out_idx and out_last are functions of registered state only. They hold stable while out_valid && !out_ready.
- On an out handshake with idx<M-1: idx increments.
- On an out handshake with idx==M-1 (last):
  - With a simultaneous input accept: reload the vector, idx=0, stay BUSY. No bubble.
  - Otherwise: return to IDLE.
- in_valid in BUSY, other than on the last-element handshake: ignored. Upstream holds it.
- Requant, per element x:
  - If shift>0: r = (x + 2^(shift-1)) >>> shift, computed in ACC_WIDTH+1 bits so the add cannot overflow. Arithmetic shift gives round-half-up toward +inf.
  - If shift==0: r = x.
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - If relu_en and the saturated value < 0: activation per Optional Feature.
- The shift and relu_en captured with a vector apply to all M elements of that vector.
- Reset asserted mid-burst: out_valid drops immediately (async). The in-flight vector is discarded. IDLE on release.

Optional Feature:
Macro FCN_LEAKY_RELU_EN.
- Absent: relu_en=1 clamps negative values to 0.
- Defined: relu_en=1 maps negative value v to v >>> 3 (floor), e.g. -1000 -> -125, -1 -> -1.
- Non-negative values and relu_en=0 behave identically in both builds.

Decomposition:
- Package fcn_pkg:
  - default DATA_WIDTH/ACC_WIDTH/SHIFT_WIDTH localparams
  - state enum typedef (IDLE, BUSY)
  - LEAKY_SHIFT=3 constant
  - saturation limit constants derived from DATA_WIDTH
- One combinational sub-module fcn_requant_unit (x, shift, relu_en -> y): round, shift, saturate, activate. Instantiated once, fed by the registered vector element selected by idx.

Test Plan (M=4, DATA_WIDTH=16, ACC_WIDTH=32):
1. in_vec={1000,-1000,70000,5}, shift=0, relu=0, out_ready=1 -> out 1000,-1000,32767,5 on 4 consecutive cycles; idx 0..3; out_last only on idx 3.
2. in_vec={24,23,-24,-25}, shift=4 -> 2,1,-1,-2. Also {-2147483648} shift=0 -> -32768; {2147483647} shift=31 -> 1.
3. in_vec={-1000,-1,0,300}, relu=1 -> 0,0,0,300 without macro; -125,-1,0,300 with FCN_LEAKY_RELU_EN.
4. out_ready held low 3 cycles at idx=1 -> out_data/out_idx unchanged, out_valid=1, in_ready=0; resumes with idx 2 when out_ready rises.
5. Second vector presented with in_valid=1 throughout the first burst -> accepted exactly on the idx-3 handshake; the next cycle shows idx 0 of the new vector; no idle cycle; 8 elements in 8 cycles.
6. rst pulsed while idx=2 -> out_valid=0 within the same cycle; after release in_ready=1, idx=0, and a new vector streams normally.
